// File: rtl/picorv32_mem_responder_if.sv
// PicoRV32 native memory bus: the initiator (core) drives the request,
// the responder returns a one-cycle ready pulse with read data.
interface picorv32_mem_responder_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_mem_responder.sv
// Word-addressed RAM responder for the PicoRV32 native memory interface with
// programmable wait states, sticky protocol/range error flags and a txn counter.
module picorv32_mem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] OOR_RDATA = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    picorv32_mem_responder_if.slave    mem,
    input  logic [3:0]                 wait_cycles,
    output logic                       proto_err,
    output logic                       oor_err,
    output logic [31:0]                txn_count
);

    localparam int unsigned AW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [30:0] WORD_LIMIT = 31'(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        logic        oor;
    } req_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    req_t        req, bus_req, cur_req;
    logic        ready_q;
    logic [31:0] rdata_q, rdata_nxt;
    logic        accept;
    logic        accept_viol;
    logic        hold_viol;
    logic        wr_en;

    logic [31:0] ram [MEM_WORDS];

    assign mem.mem_ready = ready_q;
    assign mem.mem_rdata = rdata_q;

    // Request as presented on the bus this cycle, with its range decision.
    always_comb begin
        bus_req.addr  = mem.mem_addr;
        bus_req.wdata = mem.mem_wdata;
        bus_req.wstrb = mem.mem_wstrb;
        bus_req.instr = mem.mem_instr;
        bus_req.oor   = ({1'b0, mem.mem_addr[31:2]} >= WORD_LIMIT);
    end

    assign accept  = (state == ST_IDLE) && mem.mem_valid;
    assign cur_req = (state == ST_IDLE) ? bus_req : req;

    assign accept_viol = accept &&
                         ((mem.mem_addr[1:0] != 2'b00) ||
                          (mem.mem_instr && (mem.mem_wstrb != 4'h0)));

    // While a request is outstanding the initiator must hold it stable.
    assign hold_viol = ((state == ST_WAIT) || (state == ST_RESP)) &&
                       (!mem.mem_valid || (bus_req != req));

    assign wr_en = (state == ST_RESP) && (req.wstrb != 4'h0) && !req.oor;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (mem.mem_valid) begin
                    cnt_nxt   = wait_cycles;
                    state_nxt = (wait_cycles == 4'd0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = ST_RESP;
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read data is fetched on the edge that enters RESP, so it is registered.
    always_comb begin
        rdata_nxt = '0;
        if ((state_nxt == ST_RESP) && (cur_req.wstrb == 4'h0))
            rdata_nxt = cur_req.oor ? OOR_RDATA : ram[cur_req.addr[2 +: AW]];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req       <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            proto_err <= 1'b0;
            oor_err   <= 1'b0;
            txn_count <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ready_q <= (state_nxt == ST_RESP);
            rdata_q <= rdata_nxt;
            if (accept)                   req       <= bus_req;
            if (accept_viol || hold_viol) proto_err <= 1'b1;
            if (accept && bus_req.oor)    oor_err   <= 1'b1;
            if (state == ST_RESP)         txn_count <= txn_count + 32'd1;
        end
    end

    // NOTE: RAM is deliberately not reset; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (req.wstrb[i]) ram[req.addr[2 +: AW]][8*i +: 8] <= req.wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Randomized self-checking bench for picorv32_mem_responder against a
// transaction-level model (latency 1+N, byte-merge RAM, sticky flags).
module tb_picorv32_mem_responder;

    localparam int          MEM_WORDS   = 1024;
    localparam logic [31:0] OOR_RDATA   = 32'h0000_0000;
    localparam int          MODEL_WORDS = 64;

    typedef enum int {P_NONE, P_WAITCHG, P_ADDR, P_VALID} pert_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  wait_cycles = 4'd0;
    logic        proto_err;
    logic        oor_err;
    logic [31:0] txn_count;

    picorv32_mem_responder_if bus();

    picorv32_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .OOR_RDATA (OOR_RDATA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem         (bus),
        .wait_cycles (wait_cycles),
        .proto_err   (proto_err),
        .oor_err     (oor_err),
        .txn_count   (txn_count)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_mem [MODEL_WORDS];
    logic        exp_proto;
    logic        exp_oor;
    logic [31:0] exp_count;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_proto"}, {31'b0, proto_err}, {31'b0, exp_proto});
        check({tag, "_oor"},   {31'b0, oor_err},   {31'b0, exp_oor});
        check({tag, "_count"}, txn_count, exp_count);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset         = 1'b1;
        bus.mem_valid = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b0;
        exp_proto = 1'b0;
        exp_oor   = 1'b0;
        exp_count = '0;
    endtask

    // One complete transaction: drive, measure latency, check data and status.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic instr,
                           input int nwait, input pert_t pert,
                           output logic [31:0] got_rdata);
        int          lat;
        int          word;
        logic        in_range;
        logic [31:0] exp_rdata;

        word     = int'(addr >> 2);
        in_range = ((addr >> 2) < 32'(MEM_WORDS));
        if (addr[1:0] != 2'b00 || (instr && wstrb != 4'h0) || pert == P_ADDR || pert == P_VALID)
            exp_proto = 1'b1;
        if (!in_range) exp_oor = 1'b1;
        if (wstrb != 4'h0)  exp_rdata = 32'h0;
        else if (!in_range) exp_rdata = OOR_RDATA;
        else                exp_rdata = model_mem[word];

        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        bus.mem_instr = instr;
        wait_cycles   = 4'(nwait);

        lat       = -1;
        got_rdata = 'x;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (bus.mem_ready === 1'b1) begin
                lat       = c;
                got_rdata = bus.mem_rdata;
                break;
            end
            check("rdata_not_ready", bus.mem_rdata, 32'h0);
            @(posedge clk); #1;
            if (c + 1 == 2) begin
                case (pert)
                    P_WAITCHG: wait_cycles   = 4'd0;
                    P_ADDR:    bus.mem_addr  = addr + 32'd4;
                    P_VALID:   bus.mem_valid = 1'b0;
                    default:   ;
                endcase
            end
        end
        check("latency", 32'(lat), 32'(1 + nwait));
        check("rdata", got_rdata, exp_rdata);

        if (wstrb != 4'h0 && in_range) begin
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) model_mem[word][8*i +: 8] = wdata[8*i +: 8];
        end
        exp_count = exp_count + 32'd1;

        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = $urandom;
        bus.mem_wstrb = 4'($urandom);
        @(negedge clk);
        check("ready_pulse_end", {31'b0, bus.mem_ready}, 32'h0);
        check("rdata_after", bus.mem_rdata, 32'h0);
        check_status("txn");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic        instr;
        int          nwait;
        int          r;
        pert_t       pert;

        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        exp_proto = 1'b0;
        exp_oor   = 1'b0;
        exp_count = '0;

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_ready", {31'b0, bus.mem_ready}, 32'h0);
        check("reset_rdata", bus.mem_rdata, 32'h0);
        check_status("reset");

        // Give every modelled word a known value.
        for (int i = 0; i < MODEL_WORDS; i++)
            run_txn(32'(i) << 2, $urandom, 4'hF, 1'b0, 0, P_NONE, rd);
        do_reset();

        // Basic write/read with no wait states.
        run_txn(32'h10, 32'hA5A5_1234, 4'hF, 1'b0, 0, P_NONE, rd);
        run_txn(32'h10, 32'h0, 4'h0, 1'b0, 0, P_NONE, rd);
        check("basic_rdata", rd, 32'hA5A5_1234);
        check("basic_count", txn_count, 32'd2);

        // Byte strobes.
        run_txn(32'h20, 32'h1122_3344, 4'hF, 1'b0, 0, P_NONE, rd);
        run_txn(32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0, 0, P_NONE, rd);
        run_txn(32'h20, 32'h0, 4'h0, 1'b0, 0, P_NONE, rd);
        check("strobe_rdata", rd, 32'h11BB_33DD);

        // Wait states, including a mid-transaction change and the maximum.
        run_txn(32'h10, 32'h0, 4'h0, 1'b0, 5, P_NONE, rd);
        run_txn(32'h10, 32'h0, 4'h0, 1'b0, 5, P_WAITCHG, rd);
        run_txn(32'h10, 32'h0, 4'h0, 1'b0, 15, P_NONE, rd);

        // Protocol violations, each from a clean flag state.
        do_reset();
        run_txn(32'h10, 32'h0, 4'h0, 1'b0, 4, P_ADDR, rd);
        check("addr_change_rdata", rd, 32'hA5A5_1234);
        do_reset();
        run_txn(32'h10, 32'h0, 4'h0, 1'b0, 4, P_VALID, rd);
        do_reset();
        run_txn(32'h30, 32'h5555_AAAA, 4'hF, 1'b1, 0, P_NONE, rd);
        do_reset();
        run_txn(32'h13, 32'h0, 4'h0, 1'b0, 1, P_NONE, rd);
        check("misaligned_rdata", rd, 32'hA5A5_1234);

        // Out of range: write suppressed, read returns OOR_RDATA.
        do_reset();
        run_txn(32'h0, 32'h1234_5678, 4'hF, 1'b0, 0, P_NONE, rd);
        run_txn(32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b0, 0, P_NONE, rd);
        run_txn(32'h1000, 32'h0, 4'h0, 1'b0, 0, P_NONE, rd);
        check("oor_rdata", rd, 32'h0000_0000);
        run_txn(32'h0, 32'h0, 4'h0, 1'b0, 0, P_NONE, rd);
        check("word0_kept", rd, 32'h1234_5678);

        // Reset in the middle of an 8-wait-state write aborts it.
        run_txn(32'h1003, 32'h0, 4'h0, 1'b0, 0, P_NONE, rd);
        @(posedge clk); #1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h40;
        bus.mem_wdata = 32'hDEAD_BEEF;
        bus.mem_wstrb = 4'hF;
        bus.mem_instr = 1'b0;
        wait_cycles   = 4'd8;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("rst_no_ready", {31'b0, bus.mem_ready}, 32'h0);
            @(posedge clk); #1;
            if (c + 1 == 3) reset = 1'b1;
            if (c + 1 == 4) begin
                reset         = 1'b0;
                bus.mem_valid = 1'b0;
            end
        end
        exp_proto = 1'b0;
        exp_oor   = 1'b0;
        exp_count = '0;
        check_status("after_rst");
        run_txn(32'h40, 32'h0, 4'h0, 1'b0, 2, P_NONE, rd);

        // Randomized traffic.
        do_reset();
        for (int k = 0; k < 60; k++) begin
            addr = 32'($urandom_range(0, MODEL_WORDS - 1)) << 2;
            if ($urandom_range(0, 9) == 0)
                addr = 32'h1000 + (32'($urandom_range(0, 4000)) << 2);
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            instr = (wstrb == 4'h0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            nwait = $urandom_range(0, 15);
            r     = $urandom_range(0, 7);
            pert  = (nwait >= 2 && r < 3) ? pert_t'(r + 1) : P_NONE;
            run_txn(addr, $urandom, wstrb, instr, nwait, pert, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
